// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART receive path.
package uart_pkg;

    localparam int unsigned N_BITS_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        WAIT_STOP
    } rx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock word FIFO with occupancy count; accepts a push while full if a pop happens in the same cycle.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic             do_push;
    logic             do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign count   = cnt;
    // Gated so the head reads as zero whenever nothing is buffered, including right after reset.
    assign rdata   = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// Assembles receiver bit/stop events into LSB-first words, buffers them, and flags framing/overrun/timeout.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned N_BITS         = N_BITS_DEFAULT,
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 4000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          bit_in,
    input  logic                          bit_ready,
    input  logic                          stop_valid,
    input  logic                          stop_ok,
    output logic [N_BITS-1:0]             rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          framing_err,
    output logic                          overrun_err,
    output logic                          timeout_err,
    input  logic                          clear_err
);

    localparam int unsigned BW = $clog2(N_BITS + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    rx_state_t         state, state_nx;
    logic [N_BITS-1:0] sreg, sreg_nx;
    logic [BW-1:0]     bcnt, bcnt_nx;
    logic [TW-1:0]     tcnt, tcnt_nx;
    logic              push_req;
    logic              frm_set, ovr_set, tmo_set;
    logic              fifo_full, fifo_empty, pop;
    logic              rx_event;

    assign rx_valid = ~fifo_empty;
    assign pop      = rx_valid & rx_ready;
    assign rx_event = bit_ready | stop_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            sreg        <= '0;
            bcnt        <= '0;
            tcnt        <= '0;
            framing_err <= 1'b0;
            overrun_err <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nx;
            sreg        <= sreg_nx;
            bcnt        <= bcnt_nx;
            tcnt        <= tcnt_nx;
            framing_err <= frm_set | (framing_err & ~clear_err);
            overrun_err <= ovr_set | (overrun_err & ~clear_err);
            timeout_err <= tmo_set | (timeout_err & ~clear_err);
        end
    end

    always_comb begin
        state_nx = state;
        sreg_nx  = sreg;
        bcnt_nx  = bcnt;
        tcnt_nx  = tcnt;
        push_req = 1'b0;
        frm_set  = 1'b0;
        ovr_set  = 1'b0;
        tmo_set  = 1'b0;

        case (state)
            IDLE: begin
                tcnt_nx = '0;
                if (bit_ready) begin
                    sreg_nx    = '0;
                    sreg_nx[0] = bit_in;
                    bcnt_nx    = BW'(1);
                    state_nx   = (N_BITS == 1) ? WAIT_STOP : COLLECT;
                end
            end
            COLLECT: begin
                if (bit_ready) begin
                    for (int unsigned i = 0; i < N_BITS; i++) begin
                        if (bcnt == BW'(i)) begin
                            sreg_nx[i] = bit_in;
                        end
                    end
                    bcnt_nx = bcnt + 1'b1;
                    if (bcnt == BW'(N_BITS - 1)) begin
                        state_nx = WAIT_STOP;
                    end
                end
            end
            WAIT_STOP: begin
                if (stop_valid) begin
                    if (stop_ok) begin
                        // A simultaneous pop frees a slot, so a full FIFO still takes the word.
                        if (!fifo_full || pop) begin
                            push_req = 1'b1;
                        end else begin
                            ovr_set = 1'b1;
                        end
                    end else begin
                        frm_set = 1'b1;
                    end
                    state_nx = IDLE;
                    sreg_nx  = '0;
                    bcnt_nx  = '0;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

        if (state != IDLE) begin
            if (rx_event) begin
                tcnt_nx = '0;
            end else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
                tmo_set  = 1'b1;
                state_nx = IDLE;
                sreg_nx  = '0;
                bcnt_nx  = '0;
                tcnt_nx  = '0;
            end else begin
                tcnt_nx = tcnt + 1'b1;
            end
        end
    end

    sync_fifo #(
        .WIDTH (N_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_req),
        .wdata (sreg),
        .pop   (pop),
        .rdata (rx_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Randomized bench for uart_rx_ctrl against a frame-level reference model (bit list, word queue, flag bits).
module tb_uart_rx_ctrl;

    localparam int unsigned NB    = 8;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned TMO   = 50;

    logic          clk = 1'b0;
    logic          rst;
    logic          bit_in, bit_ready, stop_valid, stop_ok, rx_ready, clear_err;
    logic [NB-1:0] rx_data;
    logic          rx_valid;
    logic [2:0]    fifo_count;
    logic          framing_err, overrun_err, timeout_err;

    uart_rx_ctrl #(
        .N_BITS         (NB),
        .FIFO_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bit_in      (bit_in),
        .bit_ready   (bit_ready),
        .stop_valid  (stop_valid),
        .stop_ok     (stop_ok),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .fifo_count  (fifo_count),
        .framing_err (framing_err),
        .overrun_err (overrun_err),
        .timeout_err (timeout_err),
        .clear_err   (clear_err)
    );

    always #5 clk = ~clk;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: bits of the frame in progress, buffered words, sticky flags.
    logic [NB-1:0] m_q[$];
    bit            m_bits[$];
    int unsigned   m_gap;
    bit            m_frm, m_ovr, m_tmo;

    task automatic model_reset();
        m_q.delete();
        m_bits.delete();
        m_gap = 0;
        m_frm = 0;
        m_ovr = 0;
        m_tmo = 0;
    endtask

    task automatic check_outputs();
        chk("rx_valid", rx_valid, m_q.size() != 0);
        chk("fifo_count", fifo_count, m_q.size());
        if (m_q.size() != 0) chk("rx_data", rx_data, m_q[0]);
        chk("framing_err", framing_err, m_frm);
        chk("overrun_err", overrun_err, m_ovr);
        chk("timeout_err", timeout_err, m_tmo);
    endtask

    // One clock cycle: drive at negedge, model the edge, check at the next negedge.
    task automatic tick(input bit bi, input bit br, input bit sv, input bit so,
                        input bit rdy, input bit clr);
        bit            f_set, o_set, t_set;
        logic [NB-1:0] word;
        bit_in     = bi;
        bit_ready  = br;
        stop_valid = sv;
        stop_ok    = so;
        rx_ready   = rdy;
        clear_err  = clr;
        @(posedge clk);
        f_set = 0; o_set = 0; t_set = 0;
        if (rdy && m_q.size() != 0) void'(m_q.pop_front());
        if (br && m_bits.size() < NB) begin
            m_bits.push_back(bi);
            m_gap = 0;
        end else if (sv && m_bits.size() == NB) begin
            word = '0;
            foreach (m_bits[i]) word = word | (NB'(m_bits[i]) << i);
            m_bits.delete();
            m_gap = 0;
            if (!so) f_set = 1;
            else if (m_q.size() < DEPTH) m_q.push_back(word);
            else o_set = 1;
        end else if (m_bits.size() != 0) begin
            if (br || sv) m_gap = 0;
            else begin
                m_gap++;
                if (m_gap == TMO) begin
                    t_set = 1;
                    m_bits.delete();
                    m_gap = 0;
                end
            end
        end
        m_frm = f_set | (m_frm & !clr);
        m_ovr = o_set | (m_ovr & !clr);
        m_tmo = t_set | (m_tmo & !clr);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle(input int unsigned n, input bit rdy);
        repeat (n) tick(0, 0, 0, 0, rdy, 0);
    endtask

    // rdy_mode: 0 holds rx_ready low during the bits, 1 randomizes it.
    task automatic send_bits(input logic [NB-1:0] w, input int unsigned nbits,
                             input bit rdy_mode, input int unsigned maxgap);
        for (int unsigned i = 0; i < nbits; i++) begin
            tick(w[i], 1, 0, 0, rdy_mode & $urandom_range(0, 1), 0);
            repeat ($urandom_range(0, maxgap)) tick(0, 0, 0, 0, rdy_mode & $urandom_range(0, 1), 0);
        end
    endtask

    task automatic send_frame(input logic [NB-1:0] w, input bit so, input bit rdy_mode,
                              input bit rdy_stop, input bit clr_stop);
        send_bits(w, NB, rdy_mode, 2);
        tick(0, 0, 1, so, rdy_stop, clr_stop);
    endtask

    task automatic drain();
        while (m_q.size() != 0) tick(0, 0, 0, 0, 1, 0);
    endtask

    initial begin
        model_reset();
        rst = 1'b1;
        {bit_in, bit_ready, stop_valid, stop_ok, rx_ready, clear_err} = '0;
        @(negedge clk);
        check_outputs();
        chk("reset_rx_data", rx_data, 0);
        rst = 1'b0;

        // Good frame 0xA5, visible one cycle after the stop edge, then a single pop.
        send_frame(8'hA5, 1, 0, 0, 0);
        chk("good_a5", rx_data, 8'hA5);
        tick(0, 0, 0, 0, 1, 0);
        chk("good_a5_popped", fifo_count, 0);

        // Framing error, clear, then a good frame.
        send_frame(8'h3C, 0, 0, 0, 0);
        chk("framing_set", framing_err, 1);
        tick(0, 0, 0, 0, 0, 1);
        send_frame(8'h11, 1, 0, 0, 0);
        chk("after_framing", rx_data, 8'h11);
        drain();

        // Overrun: five words into a four-deep FIFO with no consumer.
        for (int unsigned k = 1; k <= 5; k++) send_frame(NB'(k), 1, 0, 0, 0);
        chk("overrun_count", fifo_count, 4);
        chk("overrun_set", overrun_err, 1);
        drain();
        tick(0, 0, 0, 0, 0, 1);

        // Full FIFO with a pop on the stop cycle takes the fifth word.
        for (int unsigned k = 1; k <= 4; k++) send_frame(NB'(k), 1, 0, 0, 0);
        send_frame(8'h05, 1, 0, 1, 0);
        chk("full_pop_no_overrun", overrun_err, 0);
        drain();

        // Timeout after three bits and silence.
        send_bits(8'h07, 3, 0, 0);
        idle(TMO - 1, 0);
        chk("timeout_not_yet", timeout_err, 0);
        idle(1, 0);
        chk("timeout_fired", timeout_err, 1);
        send_frame(8'hFF, 1, 0, 0, 0);
        chk("after_timeout", rx_data, 8'hFF);
        drain();
        tick(0, 0, 0, 0, 0, 1);

        // Stray stop_valid while idle is ignored.
        tick(0, 0, 1, 1, 0, 0);
        tick(0, 0, 1, 0, 0, 0);

        // Asynchronous reset mid-operation.
        send_frame(8'h21, 1, 0, 0, 0);
        send_frame(8'h42, 1, 0, 0, 0);
        send_bits(8'h0F, 4, 0, 0);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", rx_valid, 0);
        chk("arst_count", fifo_count, 0);
        chk("arst_data", rx_data, 0);
        chk("arst_flags", {framing_err, overrun_err, timeout_err}, 0);
        model_reset();
        {bit_in, bit_ready, stop_valid, stop_ok, rx_ready, clear_err} = '0;
        @(negedge clk);
        rst = 1'b0;
        send_frame(8'h80, 1, 0, 0, 0);
        chk("after_reset_word", rx_data, 8'h80);
        chk("after_reset_count", fifo_count, 1);
        drain();

        // Clear in the same cycle as a bad stop: set wins.
        send_frame(8'h5A, 0, 0, 0, 1);
        chk("set_beats_clear", framing_err, 1);
        tick(0, 0, 0, 0, 0, 1);

        // Random traffic.
        for (int unsigned f = 0; f < 60; f++) begin
            if ($urandom_range(0, 9) == 0) begin
                send_bits(NB'($urandom), $urandom_range(1, NB - 1), 1, 2);
                idle(TMO + $urandom_range(0, 3), 0);
            end else begin
                send_frame(NB'($urandom), $urandom_range(0, 6) != 0, 1,
                           $urandom_range(0, 1), $urandom_range(0, 7) == 0);
            end
            repeat ($urandom_range(0, 4))
                tick(0, 0, $urandom_range(0, 5) == 0, $urandom_range(0, 1),
                     $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0);
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Receive-side controller that sits directly behind the UART bit receiver. It sequences the receiver's per-bit and stop-bit results into complete LSB-first words and buffers accepted words in a small FIFO. Words are presented to the system side over a valid/ready handshake. It also detects framing, overrun and mid-frame timeout conditions and reports them as sticky flags.

## Interface
- `N_BITS`, 8, data bits per frame; must match the receiver's `n_bits`.
- `FIFO_DEPTH`, 4, word buffer depth; power of two, ≥2.
- `TIMEOUT_CYCLES`, 4000, max clk cycles between consecutive receiver events inside a frame before the frame is aborted; ≥2.
- `clk`  in  1  system clock, all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `bit_in`  in  1  receiver decided bit value; qualified by `bit_ready`.
- `bit_ready`  in  1  one-cycle pulse per decided data bit.
- `stop_valid`  in  1  one-cycle pulse when the receiver has evaluated the stop bit.
- `stop_ok`  in  1  stop bit was high; qualified by `stop_valid`.
- `rx_data`  out  N_BITS  FIFO head word.
- `rx_valid`  out  1  FIFO non-empty.
- `rx_ready`  in  1  consumer accepts head word.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  words held.
- `framing_err`  out  1  sticky: stop bit low.
- `overrun_err`  out  1  sticky: good word dropped, FIFO full.
- `timeout_err`  out  1  sticky: frame aborted by timeout.
- `clear_err`  in  1  pulse, clears all sticky flags.

## Operation
- Reset values: all outputs 0, FIFO empty, state IDLE, shift register and counters 0.
- States (`rx_state_t`): IDLE, COLLECT, WAIT_STOP.
- IDLE: `bit_ready` → load `bit_in` as bit 0, bit count = 1, go to COLLECT. Bit count reaches N_BITS in the same event only if N_BITS = 1; then go to WAIT_STOP. `stop_valid` in IDLE is ignored.
- COLLECT: each `bit_ready` → `bit_in` goes to bit position [count], count+1. When count reaches N_BITS, go to WAIT_STOP.
- WAIT_STOP: `stop_valid` & `stop_ok` → push word if not full, else set `overrun_err` and drop the word. `stop_valid` & !`stop_ok` → set `framing_err` and drop the word. Both cases return to IDLE. `bit_ready` in WAIT_STOP is ignored.
- Timeout: the cycle counter clears on every `bit_ready`/`stop_valid` and on entry to COLLECT. It counts while in COLLECT/WAIT_STOP. When it reaches TIMEOUT_CYCLES: set `timeout_err`, discard the partial word, go to IDLE.
- FIFO: `rx_valid` = count≠0. Pop on `rx_valid` & `rx_ready`. Push and pop in the same cycle are both performed and count is unchanged. If full and popping in the same cycle, the push is accepted and no overrun is flagged. `rx_ready` while empty has no effect.
- Pointers wrap modulo FIFO_DEPTH. Count is width-safe up to FIFO_DEPTH.
- Sticky flags: `clear_err` clears all three. If a new error sets in the same cycle as `clear_err`, set wins.
- Reset mid-frame discards the partial word and FIFO contents immediately (async).

## Timing
- Push visible: the word is on `rx_data`/`rx_valid` in the cycle after the `stop_valid` edge (1-cycle latency), if the FIFO was empty.
- Pop: `rx_data` advances to the next word in the cycle after the accepting edge.
- Error flags assert in the cycle after the triggering edge.
- Timeout fires exactly TIMEOUT_CYCLES cycles after the last event. `timeout_err` is high on the following cycle.
- `fifo_count` is registered and consistent with `rx_valid` every cycle.

## Structure
- `uart_pkg`: `rx_state_t` enum, common `N_BITS` default constant.
- Sub-module `sync_fifo` (params WIDTH, DEPTH; push/pop/full/empty/count; async active-high `rst`), instantiated once.
- The FSM, shift register, bit counter, timeout counter and flags live in `uart_rx_ctrl`.

## Test plan
- Good frame: 8 `bit_ready` pulses with bits 1,0,1,0,0,1,0,1 (LSB first), then `stop_valid`=1/`stop_ok`=1 → `rx_data`=0xA5 and `rx_valid`=1 one cycle later; one `rx_ready` cycle → `rx_valid`=0, `fifo_count`=0.
- Framing error: frame 0x3C with `stop_ok`=0 → no push, `framing_err`=1; `clear_err` → 0; next good frame 0x11 → pushed normally.
- Overrun: `rx_ready`=0, 5 good frames 0x01..0x05 with FIFO_DEPTH=4 → `fifo_count`=4, `overrun_err`=1, drain yields 0x01..0x04. Repeat with pop on the stop cycle while full → 5th word accepted, no overrun.
- Timeout: 3 bits, then silence TIMEOUT_CYCLES cycles → `timeout_err`=1, state IDLE; next full frame 0xFF → 0xFF received intact.
- Reset mid-operation: 2 words buffered plus 4 bits in progress, assert `rst` asynchronously → all outputs 0 immediately; after release, frame 0x80 → single word 0x80.
- Simultaneous error and clear: `clear_err` in the same cycle as a bad-stop `stop_valid` → `framing_err` remains 1.
